// File: rtl/counter.sv
// Down-counter tracking remaining multiplier iterations; RESET loads INIT_VALUE.
// Optional build macro COUNTER_SATURATE_EN: stop at zero instead of wrapping and expose a zero flag.
module counter #(
  parameter int WIDTH      = 3,
  parameter int INIT_VALUE = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             DECREMENT,
  input  logic             RESET,
`ifdef COUNTER_SATURATE_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] count
);

  // Reject configurations that cannot hold the reload value at elaboration time.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "counter: WIDTH must be >= 2");
    end
    if (INIT_VALUE < 0 || INIT_VALUE >= (1 << WIDTH)) begin : g_bad_init
      $fatal(1, "counter: INIT_VALUE does not fit in WIDTH bits");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LOAD_VALUE = INIT_VALUE[WIDTH-1:0];

  // Async reset clears to zero, not LOAD_VALUE: the controller must issue RESET before use.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (RESET) begin
      count <= LOAD_VALUE;
    end else if (DECREMENT) begin
`ifdef COUNTER_SATURATE_EN
      if (count != '0) begin
        count <= count - 1'b1;
      end
`else
      count <= count - 1'b1;
`endif
    end
  end

`ifdef COUNTER_SATURATE_EN
  assign zero = (count == '0);
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: table-driven edge vectors plus hand-written async reset sequences.
// Expectations follow the COUNTER_SATURATE_EN macro when it is defined for the build.
module tb_counter;

  logic       clk;
  logic       n_reset;
  logic       DECREMENT;
  logic       RESET;
  logic [2:0] count;
`ifdef COUNTER_SATURATE_EN
  logic       zero;
`endif

  int testsRun;
  int testsFailed;

  counter #(.WIDTH(3), .INIT_VALUE(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .DECREMENT (DECREMENT),
    .RESET     (RESET),
`ifdef COUNTER_SATURATE_EN
    .zero      (zero),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dec;
    logic       rst;
    logic [2:0] expCount;
    string      name;
  } vec_t;

  localparam int NUM_VECS = 18;
  vec_t vecs [NUM_VECS];

`ifdef COUNTER_SATURATE_EN
  localparam logic [2:0] BELOW_ZERO = 3'd0;
`else
  localparam logic [2:0] BELOW_ZERO = 3'd7;
`endif

  task automatic checkOutput(input string name, input logic [2:0] expCount);
    testsRun++;
    if (count !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL %s: count=%0d expected %0d", name, count, expCount);
    end
`ifdef COUNTER_SATURATE_EN
    testsRun++;
    if (zero !== (expCount == 3'd0)) begin
      testsFailed++;
      $display("[TB] FAIL %s_zero: zero=%b expected %b", name, zero, (expCount == 3'd0));
    end
`endif
  endtask

  // Drive on the falling edge, then sample just after the following rising edge.
  task automatic applyStimulus(input logic dec, input logic rst);
    @(negedge clk);
    DECREMENT = dec;
    RESET     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    vecs[0]  = '{1'b0, 1'b1, 3'd4, "load"};
    vecs[1]  = '{1'b0, 1'b0, 3'd4, "hold1"};
    vecs[2]  = '{1'b0, 1'b0, 3'd4, "hold2"};
    vecs[3]  = '{1'b0, 1'b0, 3'd4, "hold3"};
    vecs[4]  = '{1'b1, 1'b0, 3'd3, "dec_4to3"};
    vecs[5]  = '{1'b0, 1'b0, 3'd3, "idle_3"};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, "dec_3to2"};
    vecs[7]  = '{1'b1, 1'b1, 3'd4, "reset_beats_dec"};
    vecs[8]  = '{1'b1, 1'b0, 3'd3, "run_3"};
    vecs[9]  = '{1'b1, 1'b0, 3'd2, "run_2"};
    vecs[10] = '{1'b1, 1'b0, 3'd1, "run_1"};
    vecs[11] = '{1'b1, 1'b0, 3'd0, "run_0"};
    vecs[12] = '{1'b1, 1'b0, BELOW_ZERO, "dec_at_zero"};
    vecs[13] = '{1'b0, 1'b1, 3'd4, "reload_a"};
    vecs[14] = '{1'b0, 1'b1, 3'd4, "reload_held"};
    vecs[15] = '{1'b1, 1'b1, 3'd4, "reload_held_dec"};
    vecs[16] = '{1'b1, 1'b0, 3'd3, "dec_after_reload"};
    vecs[17] = '{1'b0, 1'b0, 3'd3, "idle_before_areset"};

    DECREMENT = 1'b0;
    RESET     = 1'b0;
    n_reset   = 1'b0;
    #12;
    checkOutput("por_reset", 3'd0);

    // Inputs are ignored while n_reset is low.
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_ignores_load", 3'd0);

    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].dec, vecs[i].rst);
      checkOutput(vecs[i].name, vecs[i].expCount);
    end

    // Mid-cycle async reset from count=3 must clear before the next edge.
    #2;
    n_reset = 1'b0;
    #1;
    checkOutput("areset_immediate", 3'd0);
    @(negedge clk);
    n_reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("areset_stays_zero", 3'd0);

    // Decrement from the reset state exercises the zero boundary again.
    applyStimulus(1'b1, 1'b0);
    checkOutput("dec_from_reset_zero", BELOW_ZERO);
    applyStimulus(1'b1, 1'b0);
    checkOutput("dec_again", (BELOW_ZERO == 3'd0) ? 3'd0 : 3'd6);
    applyStimulus(1'b0, 1'b1);
    checkOutput("final_load", 3'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
